pipeline_control_irq_dispatch: RTL

//  Upstream sequencer for the IRQ-call stage. Arbitrates internal exceptions against external

---
 rtl/core_irq_pkg.sv | 18 +
 rtl/pipeline_control_irq_arbiter.sv | 38 +++
 rtl/pipeline_control_irq_dispatch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/core_irq_pkg.sv
// Shared types for the interrupt dispatch path: FSM states, vector widths, default
// external vector base.
package core_irq_pkg;

    typedef logic [6:0] irq_vector_t;
    typedef logic [5:0] irq_num_t;

    localparam irq_vector_t EXT_VEC_BASE_DEFAULT = 7'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_START,
        ST_WAIT,
        ST_JUMP
    } irq_state_t;

endpackage

// File: rtl/pipeline_control_irq_arbiter.sv
// Combinational priority select between internal exceptions and external interrupts,
// plus formation of the 7-bit call vector.
module pipeline_control_irq_arbiter
    import core_irq_pkg::*;
#(
    parameter irq_vector_t EXT_VEC_BASE = EXT_VEC_BASE_DEFAULT
) (
    input  logic        except_pend,
    input  logic [5:0]  except_pend_num,
    input  logic        except_valid,
    input  logic [5:0]  except_num,
    input  logic        irq_valid,
    input  logic [5:0]  irq_num,
    input  logic        irq_enable,
    output logic        request,
    output logic [6:0]  vector,
    output logic        src_ext
);

    always_comb begin
        request = 1'b0;
        vector  = '0;
        src_ext = 1'b0;
        // The older pending exception is serviced before a fresh pulse.
        if (except_pend) begin
            request = 1'b1;
            vector  = {1'b0, except_pend_num};
        end else if (except_valid) begin
            request = 1'b1;
            vector  = {1'b0, except_num};
        end else if (irq_valid && irq_enable) begin
            request = 1'b1;
            vector  = EXT_VEC_BASE + {1'b0, irq_num};
            src_ext = 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_control_irq_dispatch.sv
// Upstream sequencer for the IRQ-call stage: arbitrate, drain the pipeline, start the
// call, wait for the handler address, then redirect fetch and ack external sources.
module pipeline_control_irq_dispatch
    import core_irq_pkg::*;
#(
    parameter irq_vector_t EXT_VEC_BASE = EXT_VEC_BASE_DEFAULT
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iSYSREG_IM,
    input  logic        iEXCEPT_VALID,
    input  logic [5:0]  iEXCEPT_NUM,
    input  logic        iIRQ_VALID,
    input  logic [5:0]  iIRQ_NUM,
    output logic        oIRQ_ACK,
    input  logic        iPIPELINE_EMPTY,
    output logic        oPIPELINE_STALL,
    output logic        oCALL_START,
    output logic [6:0]  oCALL_NUM,
    input  logic        iCALL_FINISH,
    input  logic [31:0] iCALL_HUNDLER,
    output logic        oJUMP_VALID,
    output logic [31:0] oJUMP_ADDR
);

    irq_state_t  state;
    logic        except_pend;
    irq_num_t    except_pend_num;
    logic        arb_request;
    irq_vector_t arb_vector;
    logic        arb_src_ext;
    logic        src_ext;
    irq_vector_t call_num;
    logic [31:0] handler;
    logic        stall;
    logic        call_start;
    logic        jump_valid;
    logic        irq_ack;

    pipeline_control_irq_arbiter #(
        .EXT_VEC_BASE(EXT_VEC_BASE)
    ) u_arbiter (
        .except_pend     (except_pend),
        .except_pend_num (except_pend_num),
        .except_valid    (iEXCEPT_VALID),
        .except_num      (iEXCEPT_NUM),
        .irq_valid       (iIRQ_VALID),
        .irq_num         (iIRQ_NUM),
        .irq_enable      (iSYSREG_IM),
        .request         (arb_request),
        .vector          (arb_vector),
        .src_ext         (arb_src_ext)
    );

    // A pending exception survives an external dispatch and is only retired by its own JUMP.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            except_pend     <= 1'b0;
            except_pend_num <= '0;
        end else if (state == ST_JUMP && !src_ext) begin
            except_pend     <= 1'b0;
        end else if (iEXCEPT_VALID && !except_pend) begin
            except_pend     <= 1'b1;
            except_pend_num <= iEXCEPT_NUM;
        end
    end

    // Outputs are registered alongside the state so they decode the state being entered.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state      <= ST_IDLE;
            stall      <= 1'b0;
            call_start <= 1'b0;
            jump_valid <= 1'b0;
            irq_ack    <= 1'b0;
            call_num   <= '0;
            src_ext    <= 1'b0;
            handler    <= '0;
        end else begin
            call_start <= 1'b0;
            jump_valid <= 1'b0;
            irq_ack    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_request) begin
                        state    <= ST_DRAIN;
                        stall    <= 1'b1;
                        call_num <= arb_vector;
                        src_ext  <= arb_src_ext;
                    end
                end
                ST_DRAIN: begin
                    if (iPIPELINE_EMPTY) begin
                        state      <= ST_START;
                        call_start <= 1'b1;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (iCALL_FINISH) begin
                        state      <= ST_JUMP;
                        handler    <= iCALL_HUNDLER;
                        jump_valid <= 1'b1;
                        irq_ack    <= src_ext;
                    end
                end
                ST_JUMP: begin
                    state <= ST_IDLE;
                    stall <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    assign oPIPELINE_STALL = stall;
    assign oCALL_START     = call_start;
    assign oCALL_NUM       = call_num;
    assign oJUMP_VALID     = jump_valid;
    assign oJUMP_ADDR      = handler;
    assign oIRQ_ACK        = irq_ack;

endmodule
